// File: rtl/la_vpriority.sv
// Combinational lowest-set-bit finder: one-hot of the lowest set bit of vec and its binary index.
module la_vpriority #(
  parameter int    N    = 4,
  parameter string PROP = "DEFAULT"
) (
  input  logic [N-1:0]                      vec,
  output logic [N-1:0]                      onehot,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] id
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  // Two's-complement isolate of the lowest set bit; cell variants keep the same function.
  if (PROP == "DEFAULT") begin : g_generic
    assign onehot = vec & (~vec + N'(1));
  end else begin : g_cell
    assign onehot = vec & (~vec + N'(1));
  end

  always_comb begin
    id = '0;
    for (int i = 0; i < N; i++) begin
      if (onehot[i]) id = id | IW'(i);
    end
  end

endmodule

// File: rtl/la_vrrarb.sv
// Registered round-robin arbiter with a one-hot grant held for a whole multi-beat transfer;
// the winner of a completed transfer becomes lowest priority.
module la_vrrarb #(
  parameter int    N    = 4,
  parameter string PROP = "DEFAULT"
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [N-1:0]                         req,
  input  logic                                 ready,
  input  logic                                 last,
  output logic [N-1:0]                         gnt,
  output logic                                 gnt_valid,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] gnt_id
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t         state, state_nxt;
  logic [IW-1:0]  ptr, ptr_nxt, ptr_inc, arb_ptr;
  logic [N-1:0]   gnt_nxt;
  logic [IW-1:0]  id_nxt;
  logic           vld_nxt;
  logic           done;

  logic [N-1:0]   masked_req, masked_oh, raw_oh, win_oh;
  logic [IW-1:0]  masked_id, raw_id, win_id;

  assign done    = (state == BUSY) && ready && last;
  assign ptr_inc = (gnt_id == IW'(N - 1)) ? '0 : gnt_id + IW'(1);
  // Re-arbitration on the completing beat must already see the rotated pointer.
  assign arb_ptr = done ? ptr_inc : ptr;

  assign masked_req = req & ~((N'(1) << arb_ptr) - N'(1));

  la_vpriority #(.N(N), .PROP(PROP)) u_pri_masked (
    .vec    (masked_req),
    .onehot (masked_oh),
    .id     (masked_id)
  );

  la_vpriority #(.N(N), .PROP(PROP)) u_pri_raw (
    .vec    (req),
    .onehot (raw_oh),
    .id     (raw_id)
  );

  assign win_oh = (|masked_req) ? masked_oh : raw_oh;
  assign win_id = (|masked_req) ? masked_id : raw_id;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= '0;
      gnt       <= '0;
      gnt_id    <= '0;
      gnt_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      gnt       <= gnt_nxt;
      gnt_id    <= id_nxt;
      gnt_valid <= vld_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    gnt_nxt   = gnt;
    id_nxt    = gnt_id;
    vld_nxt   = gnt_valid;
    case (state)
      IDLE: begin
        if (|req) begin
          gnt_nxt   = win_oh;
          id_nxt    = win_id;
          vld_nxt   = 1'b1;
          state_nxt = BUSY;
        end else begin
          gnt_nxt   = '0;
          id_nxt    = '0;
          vld_nxt   = 1'b0;
        end
      end
      BUSY: begin
        // Grant is frozen until the final beat is accepted, even if its req drops.
        if (done) begin
          ptr_nxt = ptr_inc;
          if (|req) begin
            gnt_nxt = win_oh;
            id_nxt  = win_id;
            vld_nxt = 1'b1;
          end else begin
            gnt_nxt   = '0;
            id_nxt    = '0;
            vld_nxt   = 1'b0;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
